// File: rtl/eight_bit_ripple_pkg.sv
// eight_bit_ripple_pkg: shared constants and types for the ripple add/sub slice.
// Holds the default width, op encodings and the operand vector type.
package eight_bit_ripple_pkg;

   localparam int WIDTH_DEFAULT = 8;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   typedef logic [WIDTH_DEFAULT-1:0] operand_t;

endpackage

// File: rtl/eight_bit_ripple_full_adder.sv
// full_adder: 1-bit combinational full adder, one cell of the ripple chain.
// Ports: a, b, cin -> s (sum bit), cout (majority carry).
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/eight_bit_ripple.sv
// eight_bit_ripple: registered two's-complement add/sub on a ripple-carry chain.
// Ports: clk, rst (sync, active-high), in_valid, a, b, op (0 add / 1 sub) ->
// sum, overflow, out_valid one cycle later; carry_out when
// EIGHT_BIT_RIPPLE_CARRY_OUT_EN is defined.
module eight_bit_ripple
   import eight_bit_ripple_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             op,
   output logic [WIDTH-1:0] sum,
   output logic             overflow,
`ifdef EIGHT_BIT_RIPPLE_CARRY_OUT_EN
   output logic             carry_out,
`endif
   output logic             out_valid
);

   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] s;
   logic [WIDTH:0]   c;
   logic             ovf;

   // Subtract reuses the adder: invert b and inject the +1 as carry-in.
   assign b_eff = b ^ {WIDTH{op}};
   assign c[0]  = (op == OP_SUB);

   for (genvar i = 0; i < WIDTH; i++) begin : g_chain
      full_adder u_fa (
         .a    (a[i]),
         .b    (b_eff[i]),
         .cin  (c[i]),
         .s    (s[i]),
         .cout (c[i+1])
      );
   end

   // Signed overflow: carry into the sign bit differs from carry out of it.
   assign ovf = c[WIDTH] ^ c[WIDTH-1];

`ifdef EIGHT_BIT_RIPPLE_CARRY_OUT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         sum       <= '0;
         overflow  <= 1'b0;
         carry_out <= 1'b0;
         out_valid <= 1'b0;
      end else if (in_valid) begin
         sum       <= s;
         overflow  <= ovf;
         carry_out <= c[WIDTH];
         out_valid <= 1'b1;
      end else begin
         out_valid <= 1'b0;
      end
   end
`else
   always_ff @(posedge clk) begin
      if (rst) begin
         sum       <= '0;
         overflow  <= 1'b0;
         out_valid <= 1'b0;
      end else if (in_valid) begin
         sum       <= s;
         overflow  <= ovf;
         out_valid <= 1'b1;
      end else begin
         out_valid <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_eight_bit_ripple.sv
// tb_eight_bit_ripple: directed scoreboard bench for eight_bit_ripple.
// Expected results are queued at drive time and popped one cycle later.
module tb_eight_bit_ripple;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] a;
   logic [7:0] b;
   logic       op;
   logic [7:0] sum;
   logic       overflow;
   logic       out_valid;
`ifdef EIGHT_BIT_RIPPLE_CARRY_OUT_EN
   logic       carry_out;
`endif

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [7:0] sum;
      logic       ovf;
      logic       vld;
      logic       cout;
      string      tag;
   } exp_t;

   exp_t sbq[$];

   logic [7:0] m_sum  = 8'h00;
   logic       m_ovf  = 1'b0;
   logic       m_cout = 1'b0;

   eight_bit_ripple #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .op        (op),
      .sum       (sum),
      .overflow  (overflow),
`ifdef EIGHT_BIT_RIPPLE_CARRY_OUT_EN
      .carry_out (carry_out),
`endif
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   // Drive one cycle of inputs and push the model's expectation.
   task automatic drive(input logic r, input logic v,
                        input logic [7:0] aa, input logic [7:0] bb,
                        input logic o, input string tag);
      exp_t e;
      int   sa;
      int   sb;
      int   res;
      rst      = r;
      in_valid = v;
      a        = aa;
      b        = bb;
      op       = o;
      e.vld    = 1'b0;
      if (r) begin
         m_sum  = 8'h00;
         m_ovf  = 1'b0;
         m_cout = 1'b0;
      end else if (v) begin
         sa     = $signed(aa);
         sb     = $signed(bb);
         res    = o ? (sa - sb) : (sa + sb);
         m_sum  = res[7:0];
         m_ovf  = (res > 127) || (res < -128);
         m_cout = o ? (aa >= bb) : ((32'(aa) + 32'(bb)) > 255);
         e.vld  = 1'b1;
      end
      e.sum  = m_sum;
      e.ovf  = m_ovf;
      e.cout = m_cout;
      e.tag  = tag;
      sbq.push_back(e);
   endtask

   // Wait past the next rising edge and compare against the oldest entry.
   task automatic check_one();
      exp_t e;
      @(posedge clk);
      #1;
      checks++;
      assert (sbq.size() != 0) else begin
         failures++;
         $error("FAIL scoreboard_empty observed=0 expected=1");
      end
      if (sbq.size() != 0) begin
         e = sbq.pop_front();
         checks++;
         assert (sum === e.sum) else begin
            failures++;
            $error("FAIL %s.sum observed=%h expected=%h", e.tag, sum, e.sum);
         end
         checks++;
         assert (overflow === e.ovf) else begin
            failures++;
            $error("FAIL %s.ovf observed=%b expected=%b",
                   e.tag, overflow, e.ovf);
         end
         checks++;
         assert (out_valid === e.vld) else begin
            failures++;
            $error("FAIL %s.valid observed=%b expected=%b",
                   e.tag, out_valid, e.vld);
         end
`ifdef EIGHT_BIT_RIPPLE_CARRY_OUT_EN
         checks++;
         assert (carry_out === e.cout) else begin
            failures++;
            $error("FAIL %s.cout observed=%b expected=%b",
                   e.tag, carry_out, e.cout);
         end
`endif
      end
   endtask

   logic [7:0] va [16];
   logic [7:0] vb [16];
   logic       vo [16];

   initial begin
      va = '{8'h01, 8'h01, 8'hFF, 8'hFF,
             8'h01, 8'h01, 8'hFF, 8'hFF,
             8'h7F, 8'h80, 8'h80, 8'h7F,
             8'h00, 8'h80, 8'h7F, 8'h3C};
      vb = '{8'h01, 8'hFF, 8'h01, 8'hFF,
             8'h01, 8'hFF, 8'h01, 8'hFF,
             8'h7F, 8'h80, 8'h01, 8'hFF,
             8'h00, 8'h00, 8'h80, 8'hC4};
      vo = '{1'b0, 1'b0, 1'b0, 1'b0,
             1'b1, 1'b1, 1'b1, 1'b1,
             1'b0, 1'b0, 1'b1, 1'b1,
             1'b1, 1'b1, 1'b1, 1'b0};

      // Reset state.
      drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, "reset");
      check_one();
      drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, "reset2");
      check_one();

      // Isolated operations separated by idle cycles (outputs hold).
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, 1'b1, va[i], vb[i], vo[i], $sformatf("op%0d", i));
         check_one();
         drive(1'b0, 1'b0, 8'hA5, 8'h5A, 1'b1, $sformatf("hold%0d", i));
         check_one();
      end

      // Reset with a valid operation present discards it.
      drive(1'b1, 1'b1, 8'h7F, 8'h7F, 1'b0, "rst_mid");
      check_one();
      drive(1'b0, 1'b0, 8'h7F, 8'h7F, 1'b0, "rst_hold");
      check_one();
      drive(1'b0, 1'b0, 8'h12, 8'h34, 1'b1, "rst_hold2");
      check_one();

      // Back-to-back stream: one result per cycle.
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, 1'b1, va[i], vb[i], vo[i], $sformatf("b2b%0d", i));
         check_one();
      end

      // Random burst.
      for (int i = 0; i < 64; i++) begin
         drive(1'b0, 1'($urandom_range(0, 3) != 0),
               8'($urandom), 8'($urandom), 1'($urandom),
               $sformatf("rnd%0d", i));
         check_one();
      end

      drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, "tail");
      check_one();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/eight_bit_ripple.md
Name: eight_bit_ripple

Overview:
- 8-bit two's-complement adder/subtractor built as a ripple-carry chain of full adders.
- Result and signed-overflow flag are registered one clock after operands are presented.
- Serves as the integer ALU add/sub slice in the datapath.
- Subtraction is A + ~B + 1, using one shared ripple chain.

Parameters:
- WIDTH, 8, operand/result width in bits. Only 8 is verified; the chain structure must be generic in WIDTH.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  a/b/op are sampled this cycle
- a  input  WIDTH  operand A (two's complement)
- b  input  WIDTH  operand B (two's complement)
- op  input  1  0 = add (A+B), 1 = subtract (A-B)
- sum  output  WIDTH  registered result, modulo 2^WIDTH
- overflow  output  1  registered signed-overflow flag
- out_valid  output  1  sum/overflow correspond to the operands sampled one cycle earlier

Interface rule: one clock; reset is synchronous and active-high.

Behaviour:
- Combinational core:
  - b_eff[i] = b[i] XOR op
  - c[0] = op
  - s[i] = a[i] ^ b_eff[i] ^ c[i]
  - c[i+1] = majority(a[i], b_eff[i], c[i]), for i = 0..WIDTH-1
- Overflow = c[WIDTH] XOR c[WIDTH-1]. This equals "operands, after b inversion, share a sign that differs from the result's sign."
- Wrap-around: the result is always the low WIDTH bits. Unsigned carry/borrow does not affect overflow.
- Registers, on rising clk:
  - If rst: sum <= 0, overflow <= 0, out_valid <= 0.
  - Else if in_valid: sum <= s, overflow <= ovf, out_valid <= 1.
  - Else: sum and overflow hold their previous values; out_valid <= 0.
- Latency: exactly 1 cycle. Throughput: 1 operation per cycle. No back-pressure.
- Reset mid-stream: an operation presented in the same cycle as rst is discarded and outputs clear. The first valid result appears one cycle after the first in_valid with rst low.
- op, a and b are don't-care when in_valid = 0.
- The 8-stage ripple must meet timing in one cycle. No lookahead logic is permitted (the design is ripple by definition).

Optional Feature:
- Macro: EIGHT_BIT_RIPPLE_CARRY_OUT_EN
- When defined: adds output port carry_out (1 bit).
  - Registered alongside sum and reset to 0.
  - Value is c[WIDTH].
  - For add: unsigned carry. For subtract: 1 means no borrow (A >= B unsigned).
- When undefined: the port is absent and c[WIDTH] is used only for overflow.

Decomposition:
- Package eight_bit_ripple_pkg holds:
  - localparam WIDTH_DEFAULT = 8
  - OP_ADD = 1'b0, OP_SUB = 1'b1
  - a typedef for the WIDTH-bit operand vector
- One sub-module, full_adder: 1-bit inputs a, b, cin; outputs s, cout; purely combinational. Instantiated WIDTH times in a generate loop.

Test Plan:
- Add and subtract basics, in_valid=1, rst low; check one cycle later:
  - a=01, b=01, op=0 -> sum=02, ovf=0
  - a=01, b=FF, op=0 -> sum=00, ovf=0
  - a=FF, b=01, op=0 -> sum=00, ovf=0
  - a=FF, b=FF, op=0 -> sum=FE, ovf=0
- Subtract:
  - 01-01 -> sum=00, ovf=0
  - 01-FF -> sum=02, ovf=0
  - FF-01 -> sum=FE, ovf=0
  - FF-FF -> sum=00, ovf=0
- Signed overflow:
  - 7F+7F -> sum=FE, ovf=1
  - 80+80 -> sum=00, ovf=1
  - 80-01 -> sum=7F, ovf=1
  - 7F-FF -> sum=80, ovf=1
- Reset and hold:
  - Assert rst with in_valid=1, a=7F, b=7F -> next cycle sum=00, ovf=0, out_valid=0.
  - Then drop in_valid -> outputs hold and out_valid=0.
- Back-to-back: issue the full add/sub sequence on consecutive cycles -> each result appears exactly 1 cycle later with out_valid=1 every cycle.
- With EIGHT_BIT_RIPPLE_CARRY_OUT_EN defined:
  - FF+01 -> carry_out=1
  - 01-FF -> carry_out=0
  - FF-01 -> carry_out=1
